// File: rtl/bbox_pkg.sv
// Shared definitions for the bounding-box pipeline: default widths, the box
// record handed from the box finder, and the crop/scale FSM states.
package bbox_pkg;

  localparam int unsigned DEF_COORD_W = 7;
  localparam int unsigned DEF_PIX_W   = 8;

  typedef struct packed {
    logic [DEF_COORD_W-1:0] x_min;
    logic [DEF_COORD_W-1:0] y_min;
    logic [DEF_COORD_W-1:0] x_max;
    logic [DEF_COORD_W-1:0] y_max;
  } bbox_t;

  typedef enum logic [2:0] {
    IDLE,
    DIV_X,
    DIV_Y,
    SCAN,
    FLUSH,
    DONE
  } state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, W cycles per divide.
// Ports:
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   start                 : one-cycle request; dividend/divisor sampled here
//   dividend, divisor     : W-bit operands
//   quotient, remainder   : results, stable from done until the next start
//   done                  : one-cycle pulse when the results become valid
module seq_divider #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         done
);

  localparam int unsigned CNT_W = $clog2(W);

  logic [W-1:0]     rem, quo, dvs;
  logic [W-1:0]     src_rem, src_quo, src_dvs;
  logic [W-1:0]     rem_next, quo_next;
  logic [W:0]       shifted;
  logic             fits;
  logic             running;
  logic [CNT_W-1:0] cnt;

  // The start cycle already performs the first step straight from the
  // operand inputs, so a full divide occupies exactly W cycles.
  always_comb begin
    src_rem  = start ? '0 : rem;
    src_quo  = start ? dividend : quo;
    src_dvs  = start ? divisor : dvs;
    shifted  = {src_rem, src_quo[W-1]};
    fits     = shifted >= {1'b0, src_dvs};
    rem_next = fits ? W'(shifted - {1'b0, src_dvs}) : shifted[W-1:0];
    quo_next = {src_quo[W-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem     <= rem_next;
        quo     <= quo_next;
        dvs     <= divisor;
        cnt     <= CNT_W'(W - 1);
        running <= 1'b1;
      end else if (running) begin
        rem <= rem_next;
        quo <= quo_next;
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/bbox_crop_scale.sv
// Crops the source image to an inclusive bounding box and writes an
// OUT_W x OUT_H nearest-neighbour thumbnail to an output RAM.
// Ports:
//   CLOCK_50, reset       : clock, synchronous active-high reset
//   start                 : job request, accepted only in IDLE
//   x_min..y_max          : inclusive box, latched on accepted start
//   src_addr / src_data   : source RAM read port {y, x}, 1-cycle read latency
//   dst_addr/data/we      : thumbnail write port {j, i}
//   busy, done, err       : job status (done/err are levels)
module bbox_crop_scale
  import bbox_pkg::*;
#(
  parameter int unsigned COORD_W = DEF_COORD_W,
  parameter int unsigned PIX_W   = DEF_PIX_W,
  parameter int unsigned OUT_W   = 16,
  parameter int unsigned OUT_H   = 16
) (
  input  logic                            CLOCK_50,
  input  logic                            reset,
  input  logic                            start,
  input  logic [COORD_W-1:0]              x_min,
  input  logic [COORD_W-1:0]              y_min,
  input  logic [COORD_W-1:0]              x_max,
  input  logic [COORD_W-1:0]              y_max,
  output logic [2*COORD_W-1:0]            src_addr,
  input  logic [PIX_W-1:0]                src_data,
  output logic [$clog2(OUT_W*OUT_H)-1:0]  dst_addr,
  output logic [PIX_W-1:0]                dst_data,
  output logic                            dst_we,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);

  localparam int unsigned DW = COORD_W + 1;
  localparam int unsigned IW = $clog2(OUT_W);
  localparam int unsigned JW = $clog2(OUT_H);

  state_t             state, state_next;
  logic [COORD_W-1:0] bx_min, by_min, bx_max, by_max;
  logic [DW-1:0]      w_in, h_box;
  logic               box_ok;
  logic               div_start, div_done;
  logic [DW-1:0]      div_dividend, div_divisor, div_quo, div_rem;
  logic [DW-1:0]      stepx_int, stepy_int;
  logic [IW-1:0]      stepx_frac, i, rx;
  logic [JW-1:0]      stepy_frac, j, ry;
  logic [DW-1:0]      qx, qy;
  logic [IW:0]        rx_sum;
  logic [JW:0]        ry_sum;
  logic               last_col, last_px;
  logic               unused_bits;

  assign w_in   = {1'b0, x_max} - {1'b0, x_min} + DW'(1);
  assign h_box  = {1'b0, by_max} - {1'b0, by_min} + DW'(1);
  assign box_ok = (x_max >= x_min) && (y_max >= y_min);

  // x is divided from the live ports in the start cycle, y from the latched
  // box once x finishes; the divider latches its divisor on start.
  assign div_dividend = (state == IDLE) ? w_in : h_box;
  assign div_divisor  = (state == IDLE) ? DW'(OUT_W) : DW'(OUT_H);

  seq_divider #(.W(DW)) u_div (
    .clk       (CLOCK_50),
    .reset     (reset),
    .start     (div_start),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  // Power-of-two output size: the carry out of the remainder sum is the
  // "rem >= OUT" test and the low bits are already the wrapped remainder.
  assign rx_sum   = {1'b0, rx} + {1'b0, stepx_frac};
  assign ry_sum   = {1'b0, ry} + {1'b0, stepy_frac};
  assign last_col = (i == IW'(OUT_W - 1));
  assign last_px  = last_col && (j == JW'(OUT_H - 1));

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = box_ok ? DIV_X : DONE;
      DIV_X:   if (div_done) state_next = DIV_Y;
      DIV_Y:   if (div_done) state_next = SCAN;
      SCAN:    if (last_px) state_next = FLUSH;
      FLUSH:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    div_start = 1'b0;
    src_addr  = '0;
    case (state)
      IDLE:  div_start = start && box_ok;
      DIV_X: div_start = div_done;
      SCAN:  src_addr  = {by_min + qy[COORD_W-1:0], bx_min + qx[COORD_W-1:0]};
      default: ;
    endcase
  end

  assign dst_data = dst_we ? src_data : '0;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      busy <= 1'b0;  done <= 1'b0;  err <= 1'b0;
      dst_we <= 1'b0;  dst_addr <= '0;
      bx_min <= '0;  by_min <= '0;  bx_max <= '0;  by_max <= '0;
      stepx_int <= '0;  stepx_frac <= '0;  stepy_int <= '0;  stepy_frac <= '0;
      i <= '0;  j <= '0;  qx <= '0;  rx <= '0;  qy <= '0;  ry <= '0;
    end else begin
      dst_we   <= (state == SCAN);
      dst_addr <= {j, i};
      case (state)
        IDLE: if (start) begin
          bx_min <= x_min;  by_min <= y_min;  bx_max <= x_max;  by_max <= y_max;
          busy <= box_ok;
          done <= !box_ok;
          err  <= !box_ok;
          i <= '0;  j <= '0;  qx <= '0;  rx <= '0;  qy <= '0;  ry <= '0;
        end
        DIV_X: if (div_done) begin
          stepx_int  <= div_quo;
          stepx_frac <= div_rem[IW-1:0];
        end
        DIV_Y: if (div_done) begin
          stepy_int  <= div_quo;
          stepy_frac <= div_rem[JW-1:0];
        end
        SCAN: begin
          if (last_col) begin
            i  <= '0;  qx <= '0;  rx <= '0;
            j  <= j + 1'b1;
            ry <= ry_sum[JW-1:0];
            qy <= qy + stepy_int + DW'(ry_sum[JW]);
          end else begin
            i  <= i + 1'b1;
            rx <= rx_sum[IW-1:0];
            qx <= qx + stepx_int + DW'(rx_sum[IW]);
          end
        end
        FLUSH: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign unused_bits = ^{div_rem, qx[DW-1], qy[DW-1]};

endmodule

// File: tb/tb_bbox_crop_scale.sv
// Scoreboard bench for bbox_crop_scale: each job pushes its expected
// {dst_addr, dst_data} writes; a monitor pops and compares on every dst_we.
module tb_bbox_crop_scale;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [6:0]  x_min, y_min, x_max, y_max;
  logic [13:0] src_addr;
  logic [7:0]  src_data;
  logic [7:0]  dst_addr;
  logic [7:0]  dst_data;
  logic        dst_we, busy, done, err;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  bbox_crop_scale #(.COORD_W(7), .PIX_W(8), .OUT_W(16), .OUT_H(16)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .start    (start),
    .x_min    (x_min),
    .y_min    (y_min),
    .x_max    (x_max),
    .y_max    (y_max),
    .src_addr (src_addr),
    .src_data (src_data),
    .dst_addr (dst_addr),
    .dst_data (dst_data),
    .dst_we   (dst_we),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // Ramp image: pixel = x + 5*y (mod 256).
  function automatic logic [7:0] pix(input logic [13:0] a);
    logic [7:0] x, y;
    x = {1'b0, a[6:0]};
    y = {1'b0, a[13:7]};
    return x + y * 8'd5;
  endfunction

  always @(posedge clk) src_data <= pix(src_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (dst_we === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL dst_write: unexpected write addr 0x%0h data 0x%0h, expected none",
                 dst_addr, dst_data);
      end else begin
        check("dst_write", {16'h0, dst_addr, dst_data}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic push_exp(input int x0, input int y0, input int x1, input int y1);
    int w, h, sx, sy;
    logic [13:0] a;
    w = x1 - x0 + 1;
    h = y1 - y0 + 1;
    for (int j = 0; j < 16; j++) begin
      for (int i = 0; i < 16; i++) begin
        sx = x0 + (i * w) / 16;
        sy = y0 + (j * h) / 16;
        a  = {7'(sy), 7'(sx)};
        exp_q.push_back({8'(j * 16 + i), pix(a)});
      end
    end
  endtask

  task automatic run_job(input int x0, input int y0, input int x1, input int y1,
                         input int poke, input string tag);
    int n;
    bit valid, poked;
    valid = (x1 >= x0) && (y1 >= y0);
    poked = 1'b0;
    if (valid) push_exp(x0, y0, x1, y1);
    wr_cnt = 0;
    @(negedge clk);
    x_min = 7'(x0); y_min = 7'(y0); x_max = 7'(x1); y_max = 7'(y1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    check({tag, " busy_after_start"}, {31'h0, busy}, valid ? 32'd1 : 32'd0);
    while (done !== 1'b1 && n < 1000) begin
      if (poke > 0 && !poked && wr_cnt == poke) begin
        x_min = 7'd0; y_min = 7'd0; x_max = 7'd15; y_max = 7'd15;
        start = 1'b1;
        poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, " done_latency"}, n, valid ? 32'd274 : 32'd1);
    check({tag, " err"}, {31'h0, err}, valid ? 32'd0 : 32'd1);
    check({tag, " write_count"}, wr_cnt, valid ? 32'd256 : 32'd0);
    check({tag, " leftover_expected"}, exp_q.size(), 32'd0);
    repeat (3) @(negedge clk);
    check({tag, " done_level"}, {31'h0, done}, 32'd1);
    check({tag, " busy_idle"}, {31'h0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0;
    x_min = '0; y_min = '0; x_max = '0; y_max = '0;
    repeat (3) @(negedge clk);
    check("rst src_addr", {18'h0, src_addr}, 32'd0);
    check("rst dst_addr", {24'h0, dst_addr}, 32'd0);
    check("rst dst_data", {24'h0, dst_data}, 32'd0);
    check("rst status", {28'h0, dst_we, busy, done, err}, 32'd0);
    // start together with reset must be ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rst_wins busy", {31'h0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_job(28, 29, 79, 65, 0, "ramp_box");
    run_job(0, 0, 15, 15, 0, "exact_copy");
    run_job(5, 5, 5, 5, 0, "single_px");
    run_job(40, 10, 30, 20, 0, "invalid_box");
    run_job(28, 29, 79, 65, 50, "mid_start");

    // reset in the middle of SCAN
    push_exp(28, 29, 79, 65);
    wr_cnt = 0;
    @(negedge clk);
    x_min = 7'd28; y_min = 7'd29; x_max = 7'd79; y_max = 7'd65;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      #1;
      if (wr_cnt >= 100) break;
    end
    check("abort reached_write_100", wr_cnt, 32'd100);
    reset = 1'b1;
    @(negedge clk);
    check("abort dst_we", {31'h0, dst_we}, 32'd0);
    check("abort src_addr", {18'h0, src_addr}, 32'd0);
    check("abort dst_addr", {24'h0, dst_addr}, 32'd0);
    check("abort dst_data", {24'h0, dst_data}, 32'd0);
    check("abort status", {29'h0, busy, done, err}, 32'd0);
    reset = 1'b0;
    exp_q.delete();
    wr_cnt = 0;
    repeat (5) @(negedge clk);
    check("abort no_more_writes", wr_cnt, 32'd0);

    run_job(0, 0, 15, 15, 0, "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bbox_crop_scale.md
Name: bbox_crop_scale

Overview:
- Downstream stage of the bounding-box finder: consumes xMin/yMin/xMax/yMax plus done, reads the source image RAM inside the box, and writes a fixed OUT_W x OUT_H nearest-neighbour resampled thumbnail to an output RAM.
- The thumbnail is the normalised input for the shape-classification stage that follows.

Parameters:
- COORD_W, 7, bits per source coordinate; source image is 2**COORD_W square, row-major.
- PIX_W, 8, bits per pixel, source and output.
- OUT_W, 16, output width in pixels; power of two.
- OUT_H, 16, output height in pixels; power of two.

Ports:
- CLOCK_50  in  1  sole clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- start  in  1  one-cycle request; sampled only in IDLE.
- x_min, y_min, x_max, y_max  in  COORD_W each  inclusive box; latched on accepted start.
- src_addr  out  2*COORD_W  source read address = {y, x}.
- src_data  in  PIX_W  source pixel; valid exactly 1 cycle after src_addr.
- dst_addr  out  log2(OUT_W*OUT_H)  output write address = {j, i}.
- dst_data  out  PIX_W  pixel to write.
- dst_we  out  1  write strobe.
- busy  out  1  high from accepted start until done rises.
- done  out  1  level; high after a job completes, cleared by the next accepted start or reset.
- err  out  1  level; set with done when the box is invalid.

Behaviour:
- Reset values: src_addr=0, dst_addr=0, dst_data=0, dst_we=0, busy=0, done=0, err=0; FSM=IDLE. Reset mid-job aborts immediately with no further writes.
- start is ignored while busy. start and reset in the same cycle: reset wins.
- Widths: w = x_max - x_min + 1 and h = y_max - y_min + 1, computed COORD_W+1 bits wide.
- Invalid box: x_max < x_min or y_max < y_min. FSM goes IDLE->DONE next cycle with err=1 and zero writes.
- FSM:
  - IDLE: on start, latch inputs, clear done/err, set busy.
  - DIV_X: COORD_W+1 cycles; step_x_int = w / OUT_W, step_x_frac = w % OUT_W.
  - DIV_Y: COORD_W+1 cycles; same computation for h against OUT_H.
  - SCAN: OUT_W*OUT_H cycles; one src read per cycle, i fastest.
  - FLUSH: 1 cycle; final write.
  - DONE: done=1, busy=0; returns to IDLE in the same cycle.
- Column stepping. Source column for output i is x_min + floor(i*w/OUT_W), tracked incrementally:
  - Keep qx and rx (rx < OUT_W).
  - At i=0: qx=0, rx=0.
  - Each step: qx += step_x_int, rx += step_x_frac; if rx >= OUT_W then rx -= OUT_W and qx += 1.
  - At wrap to i=0, reset qx and rx, and advance the row accumulator (qy, ry) the same way using the y steps.
- Write pipeline: a read issued in cycle t produces dst_we=1 in cycle t+1, with dst_addr equal to the {j, i} of the cycle-t read and dst_data=src_data. Exactly OUT_W*OUT_H writes per valid job, each address written once, ascending.
- Source addresses always fall inside the box, so no clamping is needed.
- Boxes smaller than the output (w < OUT_W) replicate pixels; step_int=0 is legal.
- Latency, valid box: done rises 2*(COORD_W+1) + OUT_W*OUT_H + 2 cycles after the start cycle (274 with defaults). Invalid box: done rises 1 cycle after the start cycle.

Decomposition:
- Shared package bbox_pkg holds:
  - COORD_W and PIX_W defaults;
  - a bbox_t struct {x_min, y_min, x_max, y_max}, reused by the box finder;
  - the FSM state enum.
- One sub-module, seq_divider: restoring unsigned divider, COORD_W+1 bits, with start/done handshake. It is instantiated once and reused for x then y. The divisor is a parameter-derived constant, but the divider is kept generic.

Test Plan:
- Box (28,29,79,65) over a known ramp image -> step_x 3 r4, step_y 2 r5; output (1,0) reads src (31,29); output (15,15) reads src (76,63); 256 writes; done at cycle 274.
- Box (0,0,15,15) -> exact copy: dst[{j,i}] == src[{j,i}] for all 256 pixels.
- Box (5,5,5,5) -> all 256 writes carry src(5,5); err=0.
- Box (40,10,30,20) -> err=1, done 1 cycle after start, dst_we never asserted.
- Reset asserted at SCAN write 100 -> dst_we=0 next cycle, all outputs at reset values; a new start then completes normally.
- start pulsed again mid-SCAN -> ignored; exactly 256 writes, latched box unchanged.
